// File: rtl/octree_sram_arb.sv
// octree_sram_arb
// Two-port arbiter in front of a single-port SRAM. Port 0 is the octree
// updater, port 1 the searcher. A requester can hold the SRAM across several
// beats with rK_lock (e.g. a multi-word feature write). When both ports want
// the SRAM and nobody owns it, ownership alternates round-robin.
//
// Optional feature: define OCTREE_ARB_LOCK_TIMEOUT_EN to bound lock bursts to
// MAX_LOCK consecutive locked grants. A forced release pulses lock_err.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rK_req/lock/we/addr/wdata request side of port K (K = 0, 1)
//   rK_gnt                   combinational grant, beat accepted this cycle
//   rK_rvalid                read data valid for port K
//   r_rdata                  shared read data (mem_sram_Q pass-through)
//   mem_sram_*               registered SRAM controls (CEN/GWEN active low)
//   lock_err                 one-cycle pulse on forced lock release
module octree_sram_arb #(
  parameter int unsigned DATA_BUS_WIDTH = 64,
  parameter int unsigned ADDR_BUS_WIDTH = 64,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned MAX_LOCK       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      r0_req,
  input  logic                      r0_lock,
  input  logic                      r0_we,
  input  logic [ADDR_BUS_WIDTH-1:0] r0_addr,
  input  logic [DATA_BUS_WIDTH-1:0] r0_wdata,
  output logic                      r0_gnt,
  output logic                      r0_rvalid,
  input  logic                      r1_req,
  input  logic                      r1_lock,
  input  logic                      r1_we,
  input  logic [ADDR_BUS_WIDTH-1:0] r1_addr,
  input  logic [DATA_BUS_WIDTH-1:0] r1_wdata,
  output logic                      r1_gnt,
  output logic                      r1_rvalid,
  output logic [DATA_BUS_WIDTH-1:0] r_rdata,
  output logic                      mem_sram_CEN,
  output logic                      mem_sram_GWEN,
  output logic [ADDR_BUS_WIDTH-1:0] mem_sram_A,
  output logic [DATA_BUS_WIDTH-1:0] mem_sram_D,
  input  logic [DATA_BUS_WIDTH-1:0] mem_sram_Q,
  output logic                      lock_err
);

  if (RD_LATENCY < 1 || RD_LATENCY > 4 || MAX_LOCK < 1) begin : g_param_check
    $error("octree_sram_arb: RD_LATENCY must be 1..4 and MAX_LOCK at least 1");
  end

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;

  logic                      acc;
  logic                      sel;
  logic                      sel_we;
  logic                      sel_lock;
  logic [ADDR_BUS_WIDTH-1:0] sel_addr;
  logic [DATA_BUS_WIDTH-1:0] sel_wdata;
  state_e                    sel_own;

  logic                      cen_q, gwen_q;
  logic [ADDR_BUS_WIDTH-1:0] a_q;
  logic [DATA_BUS_WIDTH-1:0] d_q;

  // Issue stage sits alongside CEN; the tag pipe then covers RD_LATENCY.
  logic                  issue_rd_q, issue_tag_q;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_tag_q;

  // Grant: an owner that still requests keeps the SRAM; otherwise arbitrate
  // as if idle, which also gives immediate release when the owner drops req.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!rst) begin
      if (state_q == StOwn0 && r0_req) begin
        r0_gnt = 1'b1;
      end else if (state_q == StOwn1 && r1_req) begin
        r1_gnt = 1'b1;
      end else if (r0_req && r1_req) begin
        r0_gnt = last_gnt_q;
        r1_gnt = ~last_gnt_q;
      end else begin
        r0_gnt = r0_req;
        r1_gnt = r1_req;
      end
    end
  end

  always_comb begin
    acc       = r0_gnt | r1_gnt;
    sel       = r1_gnt;
    sel_we    = sel ? r1_we    : r0_we;
    sel_lock  = sel ? r1_lock  : r0_lock;
    sel_addr  = sel ? r1_addr  : r0_addr;
    sel_wdata = sel ? r1_wdata : r0_wdata;
    sel_own   = sel ? StOwn1   : StOwn0;
  end

`ifdef OCTREE_ARB_LOCK_TIMEOUT_EN
  localparam int unsigned LockCntW = $clog2(MAX_LOCK + 1);

  logic [LockCntW-1:0] lock_cnt_q, lock_cnt_d;
  logic                lock_err_q;
  logic                force_rel;

  // Counts the locked beats of the current burst, the beat that opened it
  // included, so MAX_LOCK is the longest run of locked grants one port gets.
  always_comb begin
    lock_cnt_d = '0;
    force_rel  = 1'b0;
    if (acc && sel_lock) begin
      if (state_q == sel_own) begin
        lock_cnt_d = lock_cnt_q + LockCntW'(1);
      end else begin
        lock_cnt_d = LockCntW'(1);
      end
      if (lock_cnt_d == LockCntW'(MAX_LOCK)) begin
        force_rel  = 1'b1;
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_err_q <= force_rel;
    end
  end

  assign lock_err = lock_err_q;
`else
  assign lock_err = 1'b0;
`endif

  always_comb begin
    state_d    = StIdle;
    last_gnt_d = last_gnt_q;
    if (acc) begin
      last_gnt_d = sel;
      if (sel_lock) begin
        state_d = sel_own;
      end
    end
`ifdef OCTREE_ARB_LOCK_TIMEOUT_EN
    if (force_rel) begin
      state_d = StIdle;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_gnt_q  <= 1'b1;
      cen_q       <= 1'b1;
      gwen_q      <= 1'b1;
      a_q         <= '0;
      d_q         <= '0;
      issue_rd_q  <= 1'b0;
      issue_tag_q <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cen_q      <= ~acc;
      gwen_q     <= acc ? ~sel_we : 1'b1;
      if (acc) begin
        a_q <= sel_addr;
        d_q <= sel_wdata;
      end
      issue_rd_q  <= acc & ~sel_we;
      issue_tag_q <= sel;
      for (int i = int'(RD_LATENCY) - 1; i > 0; i--) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_tag_q[i] <= pipe_tag_q[i-1];
      end
      pipe_vld_q[0] <= issue_rd_q;
      pipe_tag_q[0] <= issue_tag_q;
    end
  end

  assign mem_sram_CEN  = cen_q;
  assign mem_sram_GWEN = gwen_q;
  assign mem_sram_A    = a_q;
  assign mem_sram_D    = d_q;
  assign r_rdata       = mem_sram_Q;
  assign r0_rvalid     = pipe_vld_q[RD_LATENCY-1] & ~pipe_tag_q[RD_LATENCY-1];
  assign r1_rvalid     = pipe_vld_q[RD_LATENCY-1] &  pipe_tag_q[RD_LATENCY-1];

endmodule

// File: tb/tb_octree_sram_arb.sv
// Testbench for octree_sram_arb: behavioural SRAM, scoreboard of expected
// read returns per port, plus scenario tasks with inline expectations.
module tb_octree_sram_arb;
  localparam int DW    = 64;
  localparam int AW    = 64;
  localparam int RdLat = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req, r0_lock, r0_we, r1_req, r1_lock, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r_rdata;
  logic          mem_sram_CEN, mem_sram_GWEN;
  logic [AW-1:0] mem_sram_A;
  logic [DW-1:0] mem_sram_D, mem_sram_Q;
  logic          lock_err;

  int          checks;
  int          errors;
  int unsigned cyc;
  bit          mon_en;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  octree_sram_arb #(
    .DATA_BUS_WIDTH(DW),
    .ADDR_BUS_WIDTH(AW),
    .RD_LATENCY    (RdLat),
    .MAX_LOCK      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .r0_req       (r0_req),
    .r0_lock      (r0_lock),
    .r0_we        (r0_we),
    .r0_addr      (r0_addr),
    .r0_wdata     (r0_wdata),
    .r0_gnt       (r0_gnt),
    .r0_rvalid    (r0_rvalid),
    .r1_req       (r1_req),
    .r1_lock      (r1_lock),
    .r1_we        (r1_we),
    .r1_addr      (r1_addr),
    .r1_wdata     (r1_wdata),
    .r1_gnt       (r1_gnt),
    .r1_rvalid    (r1_rvalid),
    .r_rdata      (r_rdata),
    .mem_sram_CEN (mem_sram_CEN),
    .mem_sram_GWEN(mem_sram_GWEN),
    .mem_sram_A   (mem_sram_A),
    .mem_sram_D   (mem_sram_D),
    .mem_sram_Q   (mem_sram_Q),
    .lock_err     (lock_err)
  );

  function automatic logic [63:0] init_val(input int unsigned i);
    return (i == 7) ? 64'h0A : (64'hC0DE_0000_0000_0000 | 64'(i * 257));
  endfunction

  // Behavioural SRAM, one cycle read latency, 256 words.
  logic [DW-1:0] sram [256];
  bit   [255:0]  sram_w;
  logic [DW-1:0] sram_q;
  always @(posedge clk) begin
    if (mem_sram_CEN === 1'b0) begin
      if (mem_sram_GWEN === 1'b0) begin
        sram[mem_sram_A[7:0]]   <= mem_sram_D;
        sram_w[mem_sram_A[7:0]] <= 1'b1;
      end else begin
        sram_q <= sram_w[mem_sram_A[7:0]] ? sram[mem_sram_A[7:0]] : init_val(32'(mem_sram_A[7:0]));
      end
    end
  end
  assign mem_sram_Q = sram_q;

  // Scoreboard and pin model.
  typedef struct {
    logic [63:0] data;
    int unsigned due;
  } rd_exp_t;
  rd_exp_t q0[$];
  rd_exp_t q1[$];
  logic [DW-1:0] shadow [256];
  bit   [255:0]  sh_w;
  logic          exp_cen, exp_gwen;
  logic [AW-1:0] exp_a;
  logic [DW-1:0] exp_d;

  always @(negedge clk) begin : monitor
    rd_exp_t       e;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned   idx;
    if (mon_en) begin
      checks++;
      if (mem_sram_CEN !== exp_cen || mem_sram_GWEN !== exp_gwen) begin
        errors++;
        $display("FAIL sram_ctl cyc=%0d got CEN=%b GWEN=%b expected CEN=%b GWEN=%b",
                 cyc, mem_sram_CEN, mem_sram_GWEN, exp_cen, exp_gwen);
      end
      checks++;
      if (mem_sram_A !== exp_a || mem_sram_D !== exp_d) begin
        errors++;
        $display("FAIL sram_ad cyc=%0d got A=%h D=%h expected A=%h D=%h",
                 cyc, mem_sram_A, mem_sram_D, exp_a, exp_d);
      end
      checks++;
      if ((r0_gnt === 1'b1 && r1_gnt === 1'b1) || (rst && (r0_gnt !== 1'b0 || r1_gnt !== 1'b0))) begin
        errors++;
        $display("FAIL gnt_rule cyc=%0d got gnt=%b%b rst=%b expected at most one, none in reset",
                 cyc, r1_gnt, r0_gnt, rst);
      end
      if (q0.size() > 0 && q0[0].due == cyc) begin
        checks++;
        if (r0_rvalid !== 1'b1 || r_rdata !== q0[0].data) begin
          errors++;
          $display("FAIL r0_return cyc=%0d got rvalid=%b data=%h expected rvalid=1 data=%h",
                   cyc, r0_rvalid, r_rdata, q0[0].data);
        end
        void'(q0.pop_front());
      end else if (r0_rvalid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL r0_spurious cyc=%0d got rvalid=%b expected 0", cyc, r0_rvalid);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        checks++;
        if (r1_rvalid !== 1'b1 || r_rdata !== q1[0].data) begin
          errors++;
          $display("FAIL r1_return cyc=%0d got rvalid=%b data=%h expected rvalid=1 data=%h",
                   cyc, r1_rvalid, r_rdata, q1[0].data);
        end
        void'(q1.pop_front());
      end else if (r1_rvalid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL r1_spurious cyc=%0d got rvalid=%b expected 0", cyc, r1_rvalid);
      end
    end
    if (rst) begin
      exp_cen  = 1'b1;
      exp_gwen = 1'b1;
      exp_a    = '0;
      exp_d    = '0;
      q0.delete();
      q1.delete();
    end else if (r0_gnt === 1'b1 || r1_gnt === 1'b1) begin
      we = (r0_gnt === 1'b1) ? r0_we    : r1_we;
      a  = (r0_gnt === 1'b1) ? r0_addr  : r1_addr;
      d  = (r0_gnt === 1'b1) ? r0_wdata : r1_wdata;
      exp_cen  = 1'b0;
      exp_gwen = ~we;
      exp_a    = a;
      exp_d    = d;
      idx      = 32'(a[7:0]);
      if (we) begin
        shadow[idx] = d;
        sh_w[idx]   = 1'b1;
      end else begin
        e.data = sh_w[idx] ? shadow[idx] : init_val(idx);
        e.due  = cyc + 1 + RdLat;
        if (r0_gnt === 1'b1) q0.push_back(e);
        else q1.push_back(e);
      end
    end else begin
      exp_cen  = 1'b1;
      exp_gwen = 1'b1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_req = 1'b0; r0_lock = 1'b0; r0_we = 1'b0;
    r1_req = 1'b0; r1_lock = 1'b0; r1_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; r0_req = 1'b1; r1_req = 1'b1;
    @(negedge clk);
    checks++;
    if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt got %b%b expected 00", r1_gnt, r0_gnt);
    end
    checks++;
    if (mem_sram_CEN !== 1'b1 || mem_sram_GWEN !== 1'b1) begin
      errors++; $display("FAIL reset_ctl got CEN=%b GWEN=%b expected 1 1", mem_sram_CEN, mem_sram_GWEN);
    end
    checks++;
    if (mem_sram_A !== '0 || mem_sram_D !== '0) begin
      errors++; $display("FAIL reset_ad got A=%h D=%h expected 0 0", mem_sram_A, mem_sram_D);
    end
    checks++;
    if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0 || lock_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got rvalid=%b%b lock_err=%b expected 0", r1_rvalid, r0_rvalid, lock_err);
    end
    next_cycle();
    mon_en = 1'b1;
    rst    = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_read();
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 64'd7;
    @(negedge clk);
    checks++;
    if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin
      errors++; $display("FAIL single_gnt got %b%b expected 10", r1_gnt, r0_gnt);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (r1_rvalid !== 1'b0) begin
      errors++; $display("FAIL single_early got rvalid=%b expected 0", r1_rvalid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (r1_rvalid !== 1'b1 || r_rdata !== 64'h0A || r0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_data got r1_rvalid=%b data=%h r0_rvalid=%b expected 1 0a 0",
               r1_rvalid, r_rdata, r0_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_lock_burst();
    int run = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 9) begin
        r0_req = 1'b1; r0_we = 1'b1; r0_lock = (i < 8);
        r0_addr = 64'(4 + i); r0_wdata = 64'hB000 + 64'(i);
      end else begin
        r0_req = 1'b0; r0_lock = 1'b0;
      end
      r1_req = (i <= 9); r1_we = 1'b0; r1_addr = 64'd100;
      @(negedge clk);
      if (i < 9) begin
        checks++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
          errors++; $display("FAIL burst_stall beat=%0d got %b%b expected 01", i, r1_gnt, r0_gnt);
        end
      end else if (i == 9) begin
        checks++;
        if (r1_gnt !== 1'b1) begin
          errors++; $display("FAIL burst_handover got r1_gnt=%b expected 1", r1_gnt);
        end
      end
      if (mem_sram_CEN === 1'b0) run++;
      next_cycle();
      if (i == 9) idle_inputs();
    end
    checks++;
    if (run != 10) begin
      errors++; $display("FAIL burst_cen_run got %0d expected 10", run);
    end
  endtask

  task automatic test_round_robin();
    int g[8];
    int exp_port = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 64'(16 + i);
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 64'(32 + i);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (i < 6) begin
        checks++;
        if (r0_gnt !== (exp_port == 0) || r1_gnt !== (exp_port == 1)) begin
          errors++;
          $display("FAIL rr_gnt beat=%0d got %b%b expected port %0d", i, r1_gnt, r0_gnt, exp_port);
        end
        g[i] = exp_port;
        exp_port ^= 1;
      end
      if (i >= 2) begin
        checks++;
        if (r0_rvalid !== (g[i-2] == 0) || r1_rvalid !== (g[i-2] == 1)) begin
          errors++;
          $display("FAIL rr_rvalid cyc=%0d got %b%b expected port %0d", i, r1_rvalid, r0_rvalid, g[i-2]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_lock_timeout();
    bit r1_done = 1'b0;
    int pulses  = 0;
    int exp_pulses;
    bit e0, e1, ee;
`ifdef OCTREE_ARB_LOCK_TIMEOUT_EN
    exp_pulses = 1;
`else
    exp_pulses = 0;
`endif
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        r0_req = 1'b1; r0_we = 1'b1; r0_lock = 1'b1;
        r0_addr = 64'(40 + i); r0_wdata = 64'hD000 + 64'(i);
      end else begin
        r0_req = 1'b0; r0_lock = 1'b0;
      end
      r1_req = !r1_done && (i < 20); r1_we = 1'b0; r1_addr = 64'd60;
`ifdef OCTREE_ARB_LOCK_TIMEOUT_EN
      e1 = (i == 16);
      ee = (i == 16);
`else
      e1 = 1'b0;
      ee = 1'b0;
`endif
      e0 = (i < 20) && !e1;
      @(negedge clk);
      checks++;
      if (r0_gnt !== e0 || r1_gnt !== e1) begin
        errors++; $display("FAIL timeout_gnt beat=%0d got %b%b expected %b%b", i, r1_gnt, r0_gnt, e1, e0);
      end
      checks++;
      if (lock_err !== ee) begin
        errors++; $display("FAIL timeout_err beat=%0d got %b expected %b", i, lock_err, ee);
      end
      if (lock_err === 1'b1) pulses++;
      if (e1) r1_done = 1'b1;
      next_cycle();
    end
    idle_inputs();
    checks++;
    if (pulses != exp_pulses) begin
      errors++; $display("FAIL timeout_pulses got %0d expected %0d", pulses, exp_pulses);
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_release();
    r0_req = 1'b1; r0_we = 1'b1; r0_lock = 1'b1; r0_addr = 64'd70; r0_wdata = 64'hE0;
    @(negedge clk);
    checks++;
    if (r0_gnt !== 1'b1) begin
      errors++; $display("FAIL release_first got r0_gnt=%b expected 1", r0_gnt);
    end
    next_cycle();
    r0_addr = 64'd71; r0_wdata = 64'hE1;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 64'd72;
    @(negedge clk);
    checks++;
    if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
      errors++; $display("FAIL release_hold got %b%b expected 01", r1_gnt, r0_gnt);
    end
    next_cycle();
    r0_req = 1'b0; r0_lock = 1'b0;
    @(negedge clk);
    checks++;
    if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin
      errors++; $display("FAIL release_now got %b%b expected 10", r1_gnt, r0_gnt);
    end
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_mid_read();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 64'd50;
    @(negedge clk);
    checks++;
    if (r0_gnt !== 1'b1) begin
      errors++; $display("FAIL midrst_gnt got r0_gnt=%b expected 1", r0_gnt);
    end
    next_cycle();
    rst = 1'b1; r1_req = 1'b1;
    @(negedge clk);
    checks++;
    if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin
      errors++; $display("FAIL midrst_in_reset got %b%b expected 00", r1_gnt, r0_gnt);
    end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (mem_sram_CEN !== 1'b1 || mem_sram_GWEN !== 1'b1) begin
          errors++;
          $display("FAIL midrst_ctl got CEN=%b GWEN=%b expected 1 1", mem_sram_CEN, mem_sram_GWEN);
        end
      end
      checks++;
      if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
        errors++; $display("FAIL midrst_rvalid cyc=%0d got %b%b expected 00", i, r1_rvalid, r0_rvalid);
      end
      next_cycle();
    end
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 64'd51;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 64'd52;
    @(negedge clk);
    checks++;
    if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
      errors++; $display("FAIL midrst_tie got %b%b expected 01", r1_gnt, r0_gnt);
    end
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_lock_burst();
    test_round_robin();
    test_lock_timeout();
    test_release();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
